// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scanner with per-digit blink,
// frame-coherent data capture, PWM brightness and an enable gate.
//
// Optional build macro: SEG_DEADTIME_EN
//   defined   -> every slot is blanked while scan_cnt < DEAD_CYC (anti-ghosting)
//   undefined -> no dead time; lit digits drive from scan_cnt = 0
//
// Timing: all outputs are registered. The output cycle after the scan state
// (scan_cnt, dig_idx) shows that state. frame_start is registered the same
// way, so it coincides with the first displayed cycle of digit 0.
// Captured data, mask and brightness are bypassed on their capture cycle,
// so the first displayed cycle of a frame or slot already uses the new values.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 10000,
  parameter int BLINK_DIV  = 3000000,
  parameter int BRIGHT_W   = 3,
  parameter int DEAD_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [8*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              seg_data,
  output logic [NUM_DIGITS-1:0]   seg_com,
  output logic                    blink_phase,
  output logic                    frame_start
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

`ifdef SEG_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [8*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]   shadow_mask_q, shadow_mask_d;
  logic [BRIGHT_W-1:0]     bright_q, bright_d;
  logic [7:0]              seg_data_q, seg_data_d;
  logic [NUM_DIGITS-1:0]   seg_com_q, seg_com_d;
  logic                    frame_start_q, frame_start_d;

  logic                    slot_start;
  logic                    frame_cap;
  logic [8*NUM_DIGITS-1:0] pat_all;
  logic [NUM_DIGITS-1:0]   mask_all;
  logic [BRIGHT_W-1:0]     bright_eff;
  logic [63:0]             thresh;
  logic                    lit;
  logic                    dead_ok;
  logic                    blanked;
  logic                    visible;

  // Next-state: blink timer, scan position, frame/slot capture and output pattern.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    scan_cnt_d    = scan_cnt_q;
    dig_idx_d     = dig_idx_q;
    shadow_data_d = shadow_data_q;
    shadow_mask_d = shadow_mask_q;
    seg_data_d    = 8'h00;
    seg_com_d     = '1;

    // blink timer runs regardless of en
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    slot_start    = (scan_cnt_q == '0);
    frame_cap     = en && slot_start && (dig_idx_q == '0);
    pat_all       = frame_cap ? digit_data : shadow_data_q;
    mask_all      = frame_cap ? blink_mask : shadow_mask_q;
    bright_eff    = slot_start ? brightness : bright_q;
    bright_d      = bright_eff;
    frame_start_d = frame_cap;

    if (en) begin
      shadow_data_d = pat_all;
      shadow_mask_d = mask_all;
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_d = '0;
        dig_idx_d  = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;
      end else begin
        scan_cnt_d = scan_cnt_q + 1'b1;
      end
    end else begin
      scan_cnt_d = '0;
      dig_idx_d  = '0;
    end

    // widened so (brightness+1)*SCAN_DIV cannot overflow
    thresh  = ((64'(bright_eff) + 64'd1) * 64'(SCAN_DIV)) >> BRIGHT_W;
    lit     = 64'(scan_cnt_q) < thresh;
    dead_ok = !DEAD_EN || (32'(scan_cnt_q) >= DEAD_CYC);
    // blink uses the phase that will be shown alongside this output cycle
    blanked = mask_all[dig_idx_q] && !blink_phase_d;
    visible = en && lit && dead_ok && !blanked;

    if (visible) begin
      seg_com_d[dig_idx_q] = 1'b0;
      seg_data_d           = pat_all[{dig_idx_q, 3'b000} +: 8];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      dig_idx_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      shadow_data_q <= '0;
      shadow_mask_q <= '0;
      bright_q      <= '0;
      seg_data_q    <= 8'h00;
      seg_com_q     <= '1;
      frame_start_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      dig_idx_q     <= dig_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shadow_data_q <= shadow_data_d;
      shadow_mask_q <= shadow_mask_d;
      bright_q      <= bright_d;
      seg_data_q    <= seg_data_d;
      seg_com_q     <= seg_com_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_data    = seg_data_q;
  assign seg_com     = seg_com_q;
  assign blink_phase = blink_phase_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=8,
// BLINK_DIV=64, BRIGHT_W=3, DEAD_CYC=2). A frame-position model predicts
// every output cycle into a queue; table scenarios also check aggregate
// lit-cycle and frame counts, and short directed sequences cover the
// tear-free, brightness, enable, blink and reset corner cases.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BD = 64;
  localparam int BW = 3;
  localparam int DC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic [8*ND-1:0] digit_data = '0;
  logic [ND-1:0]   blink_mask = '0;
  logic [BW-1:0]   brightness = '1;
  logic [7:0]      seg_data;
  logic [ND-1:0]   seg_com;
  logic            blink_phase;
  logic            frame_start;

  seg_scan_ctrl #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD), .BRIGHT_W(BW), .DEAD_CYC(DC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .digit_data(digit_data),
    .blink_mask(blink_mask), .brightness(brightness), .seg_data(seg_data),
    .seg_com(seg_com), .blink_phase(blink_phase), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    d;
    logic [ND-1:0] c;
    logic          ph;
    logic          fs;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int lit_cnt = 0;
  int frm_cnt = 0;
  int cyc = 0;

  // model state, indexed by position within the frame
  int            m_pos;
  logic [31:0]   m_shadow;
  logic [ND-1:0] m_mask;
  int            m_bri;
  int            m_bcnt;
  logic          m_phase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  task automatic model_step();
    exp_t e;
    int slot, cnt, thr;
    logic on, dead;
    logic [ND-1:0] sel;
    e.d = 8'h00; e.c = '1; e.ph = 1'b1; e.fs = 1'b0;
    if (rst) begin
      m_pos = 0; m_shadow = '0; m_mask = '0; m_bri = 0; m_bcnt = 0; m_phase = 1'b1;
    end else begin
      if (m_bcnt == BD - 1) begin
        m_bcnt = 0;
        m_phase = ~m_phase;
      end else begin
        m_bcnt++;
      end
      e.ph = m_phase;
      if (en) begin
        slot = m_pos / SD;
        cnt  = m_pos % SD;
        if (m_pos == 0) begin
          m_shadow = digit_data;
          m_mask   = blink_mask;
          e.fs     = 1'b1;
        end
        if (cnt == 0) m_bri = int'(brightness);
        thr = ((m_bri + 1) * SD) >> BW;
`ifdef SEG_DEADTIME_EN
        dead = (cnt >= DC);
`else
        dead = 1'b1;
`endif
        on = (cnt < thr) && dead && !(m_mask[slot] && !m_phase);
        if (on) begin
          sel = ND'(1) << slot;
          e.c = ~sel;
          e.d = m_shadow[slot*8 +: 8];
        end
        m_pos = (m_pos + 1) % (ND * SD);
      end else begin
        m_pos = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  // one clock: model predicts at the edge, DUT compared at the falling edge
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cyc);
    end else begin
      e = exp_q.pop_front();
      chk("cycle_outputs", {16'h0, seg_data, seg_com, blink_phase, frame_start}, {16'h0, e});
    end
    if (seg_com != '1) lit_cnt++;
    if (frame_start) frm_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic            en;
    logic [8*ND-1:0] data;
    logic [ND-1:0]   mask;
    logic [BW-1:0]   bri;
    int              ncyc;
    int              exp_lit;
    int              exp_frames;
  } vec_t;

  vec_t vecs[7];

  initial begin
`ifdef SEG_DEADTIME_EN
    vecs[0] = '{1'b1, 32'hFC60DAF2, 4'b0000, 3'd7,  64, 48, 2};
    vecs[1] = '{1'b1, 32'hFC60DAF2, 4'b0010, 3'd7, 128, 84, 4};
    vecs[2] = '{1'b1, 32'hFC60DAF2, 4'b0000, 3'd1,  64,  0, 2};
    vecs[3] = '{1'b1, 32'hFC60DAF2, 4'b0000, 3'd0,  64,  0, 2};
    vecs[4] = '{1'b0, 32'hFC60DAF2, 4'b0000, 3'd7,  64,  0, 0};
    vecs[5] = '{1'b1, 32'h00000000, 4'b0000, 3'd7,  64, 48, 2};
    vecs[6] = '{1'b1, 32'h12345678, 4'b1001, 3'd3,  64, 16, 2};
`else
    vecs[0] = '{1'b1, 32'hFC60DAF2, 4'b0000, 3'd7,  64, 64, 2};
    vecs[1] = '{1'b1, 32'hFC60DAF2, 4'b0010, 3'd7, 128, 112, 4};
    vecs[2] = '{1'b1, 32'hFC60DAF2, 4'b0000, 3'd1,  64, 16, 2};
    vecs[3] = '{1'b1, 32'hFC60DAF2, 4'b0000, 3'd0,  64,  8, 2};
    vecs[4] = '{1'b0, 32'hFC60DAF2, 4'b0000, 3'd7,  64,  0, 0};
    vecs[5] = '{1'b1, 32'h00000000, 4'b0000, 3'd7,  64, 64, 2};
    vecs[6] = '{1'b1, 32'h12345678, 4'b1001, 3'd3,  64, 32, 2};
`endif

    // reset state
    do_reset();
    chk("reset_state", {20'h0, seg_data, seg_com}, {20'h0, 8'h00, 4'hF});
    chk("reset_phase", {30'h0, blink_phase, frame_start}, {30'h0, 2'b10});

    // table scenarios: each starts from reset with en/data applied at once
    for (int i = 0; i < 7; i++) begin
      do_reset();
      en = vecs[i].en;
      digit_data = vecs[i].data;
      blink_mask = vecs[i].mask;
      brightness = vecs[i].bri;
      lit_cnt = 0;
      frm_cnt = 0;
      repeat (vecs[i].ncyc) tick();
      chk($sformatf("vec%0d_lit_cycles", i), lit_cnt, vecs[i].exp_lit);
      chk($sformatf("vec%0d_frames", i), frm_cnt, vecs[i].exp_frames);
    end

    // first displayed cycle of a frame: digit 0 and frame_start together
    do_reset();
    en = 1'b1; digit_data = 32'hFC60DAF2; blink_mask = '0; brightness = 3'd7;
    repeat (3) tick();
    chk("first_digit0", {20'h0, seg_data, seg_com}, {20'h0, 8'hF2, 4'hE});

    // tear-free: data cleared at frame position 12 stays hidden until next frame
    repeat (9) tick();
    digit_data = 32'h00000000;
    repeat (8) tick();
    chk("tearfree_old_digit2", {20'h0, seg_data, seg_com}, {20'h0, 8'h60, 4'hB});
    repeat (13) tick();
    chk("tearfree_frame_start", {31'h0, frame_start}, 32'h1);
    repeat (2) tick();
    chk("tearfree_new_zero", {20'h0, seg_data, seg_com}, {20'h0, 8'h00, 4'hE});

    // brightness change mid-slot applies from the next slot
    do_reset();
    en = 1'b1; digit_data = 32'hFC60DAF2; brightness = 3'd7;
    repeat (3) tick();
    brightness = 3'd0;
    repeat (5) tick();
    chk("bright_hold_slot", {20'h0, seg_data, seg_com}, {20'h0, 8'hF2, 4'hE});
    repeat (2) tick();
    chk("bright_next_slot_dark", {20'h0, seg_data, seg_com}, {20'h0, 8'h00, 4'hF});
    brightness = 3'd7;

    // enable drop mid-slot and re-raise
    do_reset();
    en = 1'b1;
    repeat (5) tick();
    en = 1'b0;
    tick();
    chk("en_drop_dark", {20'h0, seg_data, seg_com}, {20'h0, 8'h00, 4'hF});
    repeat (3) tick();
    en = 1'b1;
    tick();
    chk("en_rise_frame_start", {31'h0, frame_start}, 32'h1);
    repeat (2) tick();
    chk("en_rise_digit0", {20'h0, seg_data, seg_com}, {20'h0, 8'hF2, 4'hE});

    // blink phase: 1 after reset, toggles after 64 cycles
    do_reset();
    en = 1'b1; blink_mask = 4'b0010;
    repeat (63) tick();
    chk("blink_phase_hold", {31'h0, blink_phase}, 32'h1);
    tick();
    chk("blink_phase_toggle", {31'h0, blink_phase}, 32'h0);
    repeat (11) tick();
    chk("blink_digit1_dark", {20'h0, seg_data, seg_com}, {20'h0, 8'h00, 4'hF});
    blink_mask = '0;

    // reset asserted mid-slot while enabled
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_slot", {18'h0, seg_data, seg_com, blink_phase, frame_start},
        {18'h0, 8'h00, 4'hF, 2'b10});
    rst = 1'b0;
    en  = 1'b0;
    tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
